// File: rtl/mips_dcache.sv
// Direct-mapped, write-through, write-allocate data cache for the MIPS MEM stage.
// One-word lines, configurable depth and memory latency, byte-store merging, hit/miss counters.
module mips_dcache #(
    parameter int NUM_LINES   = 16,
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             cache_en,
    input  logic             mem_write,
    input  logic             is_LB_SB,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [7:0]       rdata [0:3],
    output logic             hit,
    output logic             freeze,
    output logic [31:0]      mem_addr,
    output logic [7:0]       mem_data_in [0:3],
    output logic             mem_write_en,
    input  logic [7:0]       mem_data_out [0:3],
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = 30 - INDEX_W;
    localparam int CW      = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    // Byte stores replace one lane of the resident line; word stores replace all four.
    function automatic logic [31:0] merge_word(input logic [31:0] line_w,
                                               input logic [31:0] wd,
                                               input logic        byte_op,
                                               input logic [1:0]  lane);
        logic [31:0] w;
        w = line_w;
        if (byte_op) begin
            case (lane)
                2'd0:    w[7:0]   = wd[7:0];
                2'd1:    w[15:8]  = wd[7:0];
                2'd2:    w[23:16] = wd[7:0];
                2'd3:    w[31:24] = wd[7:0];
                default: w        = line_w;
            endcase
        end else begin
            w = wd;
        end
        return w;
    endfunction

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   store_q, store_d;
    logic                   refill_q, refill_d;
    logic [NUM_LINES-1:0]   valid_q;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [31:0]            line_q [NUM_LINES];
    logic [CNT_W-1:0]       hit_cnt_q, miss_cnt_q;

    logic [INDEX_W-1:0]     index_s;
    logic [TAG_W-1:0]       tag_s;
    logic [1:0]             lane_s;
    logic [31:0]            line_word_s;
    logic [31:0]            merged_s;
    logic [31:0]            fill_word_s;
    logic                   hit_inc_s, miss_inc_s, fill_we_s, wr_we_s;

    assign index_s     = addr[INDEX_W+1:2];
    assign tag_s       = addr[31:INDEX_W+2];
    assign lane_s      = addr[1:0];
    assign line_word_s = line_q[index_s];
    assign hit         = valid_q[index_s] && (tag_q[index_s] == tag_s);
    assign mem_addr    = {addr[31:2], 2'b00};
    assign merged_s    = merge_word(line_word_s, wdata, is_LB_SB, lane_s);
    assign fill_word_s = {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]};
    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;

    // Split the resident line and the merged store word into byte lanes.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rdata[k]       = line_word_s[8*k +: 8];
            mem_data_in[k] = merged_s[8*k +: 8];
        end
    end

    // Next-state, stall and strobe logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        store_d      = store_q;
        refill_d     = 1'b0;
        hit_inc_s    = 1'b0;
        miss_inc_s   = 1'b0;
        fill_we_s    = 1'b0;
        wr_we_s      = 1'b0;
        freeze       = 1'b0;
        mem_write_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cache_en) begin
                    store_d = mem_write;
                    if (hit) begin
                        // The load re-presented right after its own fill is not a new access.
                        hit_inc_s = !refill_q;
                        if (mem_write) begin
                            freeze  = 1'b1;
                            state_d = S_WRITE;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            freeze  = 1'b0;
                        end
                    end else begin
                        miss_inc_s = 1'b1;
                        freeze     = 1'b1;
                        state_d    = S_FILL;
                        cnt_d      = CNT_ZERO;
                    end
                end else begin
                    freeze = 1'b0;
                end
            end
            S_FILL: begin
                freeze = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    fill_we_s = 1'b1;
                    cnt_d     = CNT_ZERO;
                    state_d   = store_q ? S_WRITE : S_IDLE;
                    refill_d  = !store_q;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_WRITE: begin
                freeze       = 1'b1;
                mem_write_en = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    wr_we_s = 1'b1;
                    cnt_d   = CNT_ZERO;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                // One unfrozen cycle lets the held store leave MEM without replaying.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Control state, valid bits and statistics counters.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            cnt_q      <= CNT_ZERO;
            store_q    <= 1'b0;
            refill_q   <= 1'b0;
            valid_q    <= {NUM_LINES{1'b0}};
            hit_cnt_q  <= {CNT_W{1'b0}};
            miss_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            store_q  <= store_d;
            refill_q <= refill_d;
            if (fill_we_s) begin
                valid_q[index_s] <= 1'b1;
            end
            if (hit_inc_s) begin
                hit_cnt_q <= hit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (miss_inc_s) begin
                miss_cnt_q <= miss_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Tag and data arrays are qualified by valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            tag_q[index_s]  <= tag_s;
            line_q[index_s] <= fill_word_s;
        end else if (wr_we_s) begin
            line_q[index_s] <= merged_s;
        end
    end

endmodule

// File: tb/tb_mips_dcache.sv
// Directed testbench for mips_dcache (NUM_LINES=16, MEM_LATENCY=4) with a latency-aware memory model.
module tb_mips_dcache;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cache_en, mem_write, is_LB_SB;
    logic [31:0] addr, wdata;
    logic [7:0]  rdata [0:3];
    logic        hit, freeze, mem_write_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in [0:3];
    logic [7:0]  mem_data_out [0:3];
    logic [31:0] hit_count, miss_count;

    logic [31:0] rdata_w, mdin_w;
    logic [31:0] tbmem [0:1023];
    int          wcnt;
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          fz, we;
    logic [31:0] wd_seen, wa_seen;

    always #5 clk = ~clk;

    mips_dcache #(.NUM_LINES(16), .MEM_LATENCY(4), .CNT_W(32)) dut (
        .clk(clk), .rst_b(rst_b), .cache_en(cache_en), .mem_write(mem_write),
        .is_LB_SB(is_LB_SB), .addr(addr), .wdata(wdata), .rdata(rdata), .hit(hit),
        .freeze(freeze), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    assign rdata_w = {rdata[3], rdata[2], rdata[1], rdata[0]};
    assign mdin_w  = {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};

    // Memory returns the addressed word combinationally.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            mem_data_out[k] = tbmem[mem_addr[11:2]][8*k +: 8];
        end
    end

    // A write commits only after the strobe was held for four consecutive cycles.
    always @(posedge clk) begin
        if (pl_en) begin
            tbmem[pl_addr] <= pl_data;
            wcnt <= 0;
        end else if (!rst_b || !mem_write_en) begin
            wcnt <= 0;
        end else if (wcnt == 3) begin
            tbmem[mem_addr[11:2]] <= mdin_w;
            wcnt <= 0;
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    task automatic measure_stall();
        fz = 0; we = 0; wd_seen = 32'h0; wa_seen = 32'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_write_en) begin
                we++;
                wd_seen = mdin_w;
                wa_seen = mem_addr;
            end
            if (!freeze) break;
            fz++;
            @(posedge clk); #1;
        end
    endtask

    task automatic set_req(input logic en, input logic st, input logic bt,
                           input logic [31:0] a, input logic [31:0] d);
        cache_en = en; mem_write = st; is_LB_SB = bt; addr = a; wdata = d;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; pl_en = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
        pl_addr = 10'h040; pl_data = 32'h44332211;
        @(posedge clk); #1;
        pl_addr = 10'h150; pl_data = 32'h04030201;
        @(posedge clk); #1;
        pl_en = 1'b0;
        tests_run++;
        if (freeze !== 1'b0) begin tests_failed++; $display("FAIL reset_freeze_idle got %b want 0", freeze); end
        tests_run++;
        if (mem_write_en !== 1'b0) begin tests_failed++; $display("FAIL reset_mwe got %b want 0", mem_write_en); end
        tests_run++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            tests_failed++; $display("FAIL reset_counters got %0d/%0d want 0/0", hit_count, miss_count);
        end
        cache_en = 1'b1; #1;
        tests_run++;
        if (freeze !== 1'b1 || hit !== 1'b0) begin
            tests_failed++; $display("FAIL reset_access_misses got freeze=%b hit=%b want 1/0", freeze, hit);
        end
        cache_en = 1'b0;
        @(negedge clk); rst_b = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_miss();
        set_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        measure_stall();
        tests_run++;
        if (fz !== 5 || we !== 0) begin tests_failed++; $display("FAIL lw_miss_stall got fz=%0d we=%0d want 5/0", fz, we); end
        tests_run++;
        if (hit !== 1'b1 || rdata_w !== 32'h44332211) begin
            tests_failed++; $display("FAIL lw_miss_data got hit=%b rdata=%h want 1/44332211", hit, rdata_w);
        end
        tests_run++;
        if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
            tests_failed++; $display("FAIL lw_miss_counts got h=%0d m=%0d want 0/1", hit_count, miss_count);
        end
        @(posedge clk); #1;
        tests_run++;
        if (hit_count !== 32'd0) begin tests_failed++; $display("FAIL lw_reeval_uncounted got %0d want 0", hit_count); end
        @(negedge clk);
        tests_run++;
        if (freeze !== 1'b0 || hit !== 1'b1 || rdata_w !== 32'h44332211) begin
            tests_failed++; $display("FAIL lw_hit got freeze=%b hit=%b rdata=%h want 0/1/44332211", freeze, hit, rdata_w);
        end
        @(posedge clk); #1;
        cache_en = 1'b0;
        tests_run++;
        if (hit_count !== 32'd1) begin tests_failed++; $display("FAIL lw_hit_count got %0d want 1", hit_count); end
    endtask

    task automatic test_sb_hit();
        set_req(1'b1, 1'b1, 1'b1, 32'h102, 32'h000000AB);
        measure_stall();
        tests_run++;
        if (fz !== 5 || we !== 4) begin tests_failed++; $display("FAIL sb_stall got fz=%0d we=%0d want 5/4", fz, we); end
        tests_run++;
        if (wa_seen !== 32'h100 || wd_seen !== 32'h44AB2211) begin
            tests_failed++; $display("FAIL sb_write got addr=%h data=%h want 100/44ab2211", wa_seen, wd_seen);
        end
        tests_run++;
        if (mem_write_en !== 1'b0 || hit_count !== 32'd2) begin
            tests_failed++; $display("FAIL sb_done got mwe=%b hits=%0d want 0/2", mem_write_en, hit_count);
        end
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        tests_run++;
        if (freeze !== 1'b0 || hit !== 1'b1 || rdata_w !== 32'h44AB2211) begin
            tests_failed++; $display("FAIL sb_readback got freeze=%b hit=%b rdata=%h want 0/1/44ab2211", freeze, hit, rdata_w);
        end
        @(posedge clk); #1;
        cache_en = 1'b0;
        tests_run++;
        if (hit_count !== 32'd3) begin tests_failed++; $display("FAIL sb_readback_count got %0d want 3", hit_count); end
    endtask

    task automatic test_sw_miss();
        set_req(1'b1, 1'b1, 1'b0, 32'h540, 32'hDEADBEEF);
        measure_stall();
        tests_run++;
        if (fz !== 9 || we !== 4) begin tests_failed++; $display("FAIL sw_miss_stall got fz=%0d we=%0d want 9/4", fz, we); end
        tests_run++;
        if (wa_seen !== 32'h540 || wd_seen !== 32'hDEADBEEF || miss_count !== 32'd2) begin
            tests_failed++; $display("FAIL sw_miss_write got addr=%h data=%h miss=%0d want 540/deadbeef/2", wa_seen, wd_seen, miss_count);
        end
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        measure_stall();
        tests_run++;
        if (fz !== 5 || rdata_w !== 32'h44AB2211 || miss_count !== 32'd3) begin
            tests_failed++; $display("FAIL conflict_refill got fz=%0d rdata=%h miss=%0d want 5/44ab2211/3", fz, rdata_w, miss_count);
        end
        @(posedge clk); #1;
        cache_en = 1'b0;
        tests_run++;
        if (hit_count !== 32'd3) begin tests_failed++; $display("FAIL conflict_hits got %0d want 3", hit_count); end
    endtask

    task automatic test_reset_mid_write();
        set_req(1'b1, 1'b1, 1'b0, 32'h100, 32'h12345678);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if (mem_write_en !== 1'b1) begin tests_failed++; $display("FAIL rmw_in_write got %b want 1", mem_write_en); end
        #2 rst_b = 1'b0;
        #1;
        tests_run++;
        if (mem_write_en !== 1'b0 || hit !== 1'b0 || freeze !== 1'b1) begin
            tests_failed++; $display("FAIL rmw_async got mwe=%b hit=%b freeze=%b want 0/0/1", mem_write_en, hit, freeze);
        end
        tests_run++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            tests_failed++; $display("FAIL rmw_counters got %0d/%0d want 0/0", hit_count, miss_count);
        end
        cache_en = 1'b0;
        @(negedge clk); rst_b = 1'b1;
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        measure_stall();
        tests_run++;
        if (fz !== 5 || rdata_w !== 32'h44AB2211 || miss_count !== 32'd1 || hit_count !== 32'd0) begin
            tests_failed++; $display("FAIL rmw_refill got fz=%0d rdata=%h m=%0d h=%0d want 5/44ab2211/1/0",
                                     fz, rdata_w, miss_count, hit_count);
        end
        @(posedge clk); #1;
        cache_en = 1'b0;
    endtask

    task automatic test_idle_alternate();
        logic [31:0] h0, m0;
        h0 = hit_count; m0 = miss_count;
        for (int i = 0; i < 4; i++) begin
            cache_en = 1'b0;
            @(negedge clk);
            tests_run++;
            if (freeze !== 1'b0 || hit_count !== h0 + 32'(i) || miss_count !== m0) begin
                tests_failed++; $display("FAIL idle_%0d got freeze=%b h=%0d m=%0d want 0/%0d/%0d",
                                         i, freeze, hit_count, miss_count, h0 + 32'(i), m0);
            end
            @(posedge clk); #1;
            set_req(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i), 32'h0);
            @(negedge clk);
            tests_run++;
            if (freeze !== 1'b0 || hit !== 1'b1) begin
                tests_failed++; $display("FAIL alt_load_%0d got freeze=%b hit=%b want 0/1", i, freeze, hit);
            end
            @(posedge clk); #1;
        end
        cache_en = 1'b0;
        @(negedge clk);
        tests_run++;
        if (hit_count !== h0 + 32'd4 || miss_count !== m0) begin
            tests_failed++; $display("FAIL alt_counts got h=%0d m=%0d want %0d/%0d", hit_count, miss_count, h0 + 32'd4, m0);
        end
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_sb_hit();
        test_sw_miss();
        test_reset_mid_write();
        test_idle_alternate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mips_dcache.md
Name: mips_dcache

Overview:
- Parametrised, direct-mapped, write-through, write-allocate data cache for the MEM stage of the 5-stage MIPS pipeline.
- Replaces the fixed cache inside the MEM stage with a configurable depth and memory latency, and adds byte-store merging and hit/miss counters.
- Sits between the EXE_to_MEM register and the byte-lane main memory.
- Drives `freeze` to stall IF/ID/EXE/MEM while a miss fill or a write-through is in progress.

Parameters:
- NUM_LINES, 16, number of one-word lines; power of 2, at least 2; INDEX_W = clog2(NUM_LINES).
- MEM_LATENCY, 4, cycles memory needs with stable address (read) or with stable address, data and write enable (write); minimum 1.
- CNT_W, 32, width of the hit and miss counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset; asynchronous, active-low.
- cache_en  in  1  a memory request is present (LW/LB/SW/SB in MEM).
- mem_write  in  1  1 = store, 0 = load; valid when cache_en = 1.
- is_LB_SB  in  1  1 = byte access, 0 = word access.
- addr  in  32  byte address (alu_result).
- wdata  in  32  store data; byte store uses wdata[7:0].
- rdata  out  8x[0:3]  line bytes; lane k = byte at word address + k.
- hit  out  1  tag match and valid bit set for the current index.
- freeze  out  1  stall request to the pipeline.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_data_in  out  8x[0:3]  merged store word to memory.
- mem_write_en  out  1  memory write strobe.
- mem_data_out  in  8x[0:3]  memory read word.
- hit_count  out  CNT_W  accesses that hit in IDLE.
- miss_count  out  CNT_W  accesses that missed in IDLE.

Behaviour:
- Address split:
  - index = addr[INDEX_W+1:2]
  - tag = addr[31:INDEX_W+2]
  - lane = addr[1:0]
- Storage per line: valid bit, tag, 4 data bytes.
- `hit`, `rdata` and `mem_addr` are combinational from the current `addr`.
- Merge word:
  - Word store: lane k = wdata[8k+7:8k].
  - Byte store: lane `lane` = wdata[7:0]; the other lanes come from the line data.
  - The line is valid at merge time in every case (write-allocate).
- FSM states: IDLE, FILL, WRITE, DONE. Latency counter cnt is 0..MEM_LATENCY-1.
- IDLE, cache_en = 0: no action, freeze = 0.
- IDLE, load hit: freeze = 0 and rdata is valid in the same cycle; hit_count increments.
- IDLE, load miss: freeze = 1, miss_count increments, next state FILL, cnt <= 0.
- IDLE, store hit: freeze = 1, hit_count increments, next state WRITE, cnt <= 0.
- IDLE, store miss: freeze = 1, miss_count increments, next state FILL, cnt <= 0.
- FILL:
  - freeze = 1; cnt increments each cycle.
  - At cnt = MEM_LATENCY-1, capture mem_data_out into the line, set tag and valid, and clear cnt.
  - Next state is WRITE for a store, otherwise IDLE. The load then hits on re-evaluation and freeze drops.
- WRITE:
  - freeze = 1, mem_write_en = 1, mem_data_in = merged word, held for MEM_LATENCY cycles.
  - At cnt = MEM_LATENCY-1, write the merged word into the line and go to DONE.
- DONE:
  - freeze = 0 for exactly one cycle, so the pipeline advances past the store.
  - No counter update and no memory write; next state IDLE. This prevents replay of the held store.
- Stall lengths (freeze high):
  - Load miss: MEM_LATENCY+1 cycles.
  - Store hit: MEM_LATENCY+1 cycles.
  - Store miss: 2*MEM_LATENCY+1 cycles.
- mem_write_en is 0 in every state except WRITE. mem_data_in is don't-care outside WRITE but is driven with the merged word.
- Request inputs are held stable by the pipeline while freeze = 1. A change mid-FILL or mid-WRITE is illegal; the FSM completes the original operation regardless.
- Counters wrap modulo 2^CNT_W. A DONE cycle and the load re-evaluation after FILL count nothing.
- Reset (asynchronous, any state, including mid-FILL or mid-WRITE):
  - State = IDLE, cnt = 0.
  - All valid bits = 0; tag and data are not reset.
  - hit_count = 0, miss_count = 0.
  - Outputs: mem_write_en = 0. freeze = 0 while cache_en = 0, otherwise it follows the IDLE rules above (every access misses after reset).

Test Plan (NUM_LINES = 16, MEM_LATENCY = 4):
- Reset, then LW 0x100 with memory word {11,22,33,44} -> freeze high 5 cycles; mem_write_en = 0 throughout; then rdata = {11,22,33,44}, hit = 1; miss_count = 1, hit_count = 0.
- Repeat LW 0x100 -> freeze = 0, rdata valid the same cycle, hit_count = 1.
- SB 0x102 with wdata = 0xAB on a hit line -> mem_write_en high 4 cycles with mem_addr = 0x100 and mem_data_in = {11,22,AB,44}; DONE cycle with freeze = 0; a following LW 0x100 hits with {11,22,AB,44}.
- SW 0x540 with wdata = 0xDEADBEEF (index 0, conflicts with 0x100's index 0 tag) -> 4 FILL cycles, then 4 WRITE cycles with mem_data_in = {EF,BE,AD,DE}; freeze high 9 cycles; a following LW 0x100 misses.
- Assert rst_b low during cycle 2 of WRITE -> mem_write_en = 0 immediately, state IDLE, counters 0; a re-presented LW misses.
- Alternate cache_en = 0 idle cycles with loads -> counters unchanged and freeze = 0 on idle cycles.
